// File: rtl/round_robin_lock_arbiter.sv
// +--------------------------------------------------------------------------+
// | round_robin_lock_arbiter: round-robin arbiter whose grant stays locked   |
// | to its owner until the owner drops req. Option macro: ARB_TIMEOUT_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module round_robin_lock_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grant_vld,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Unsupported sizes leave nothing meaningful to build.
  if (N < 2 || MAX_HOLD < 2) begin : g_param_guard
  end

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          grant_vld_q, grant_vld_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW:0]   pick;
  logic          owner_req;

  // Returns {found, index} of the first set bit scanning upward from base, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] vec, input logic [IW-1:0] base);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(base) + k) % N);
      if (!res[IW] && vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == N - 1) ? '0 : i + IW'(1);
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;
  logic [N-1:0]  others;
`endif

  assign owner_req = req[grant_id_q];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_vld_d = grant_vld_q;
    grant_id_d  = grant_id_q;
    pick        = '0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
    others      = req;
`endif
    case (state_q)
      ST_IDLE: begin
        pick = rr_pick(req, ptr_q);
        if (pick[IW]) begin
          grant_id_d  = pick[IW-1:0];
          grant_vld_d = 1'b1;
          state_d     = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d  = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (!owner_req) begin
          // Release: rotate past the owner and re-arbitrate on the same edge.
          ptr_d = next_idx(grant_id_q);
          pick  = rr_pick(req, ptr_d);
          if (pick[IW]) begin
            grant_id_d = pick[IW-1:0];
          end else begin
            grant_id_d  = '0;
            grant_vld_d = 1'b0;
            state_d     = ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
          // Forced release; with no competitor the owner simply keeps the grant.
          ptr_d              = next_idx(grant_id_q);
          others[grant_id_q] = 1'b0;
          pick               = rr_pick(others, ptr_d);
          if (pick[IW]) grant_id_d = pick[IW-1:0];
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
`endif
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_vld_d = 1'b0;
        grant_id_d  = '0;
      end
    endcase
    grant_d = grant_vld_d ? ({{(N-1){1'b0}}, 1'b1} << grant_id_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_vld_q <= 1'b0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      grant_vld_q <= grant_vld_d;
      grant_id_q  <= grant_id_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant     = grant_q;
  assign grant_vld = grant_vld_q;
  assign grant_id  = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_round_robin_lock_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_round_robin_lock_arbiter: directed bench with a behavioural model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_round_robin_lock_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam int HOLD2 = 5;
`else
  localparam int HOLD2 = 10;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic         grant_vld;
  logic [1:0]   grant_id;
  logic         timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: owner index (-1 when idle), priority pointer, visible grant cycles, timeout pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  logic m_to  = 1'b0;

  round_robin_lock_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .grant_vld(grant_vld),
    .grant_id (grant_id),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  function automatic int first_from(input logic [N-1:0] vec, input int base);
    for (int k = 0; k < N; k++) begin
      if (vec[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    int w;
    logic [N-1:0] others;
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_held  <= 0;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_owner < 0) begin
        m_owner <= first_from(req, m_ptr);
        m_held  <= 1;
      end else if (!req[m_owner]) begin
        m_ptr   <= (m_owner + 1) % N;
        m_owner <= first_from(req, (m_owner + 1) % N);
        m_held  <= 1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_held == MAX_HOLD) begin
        others          = req;
        others[m_owner] = 1'b0;
        w               = first_from(others, (m_owner + 1) % N);
        m_ptr   <= (m_owner + 1) % N;
        m_owner <= (w < 0) ? m_owner : w;
        m_held  <= 1;
        m_to    <= 1'b1;
      end
`endif
      else begin
        m_held <= m_held + 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] eg;
    logic [1:0]   eid;
    eg  = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    chk("model_outputs", {24'd0, grant, grant_vld, grant_id, timeout},
        {24'd0, eg, (m_owner >= 0), eid, m_to});
  end

  initial begin : stim
    int cnt;
    // 1. Reset with all requests pending.
    #2 rst_n = 1'b0;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("reset_grant", grant, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", grant, 4'b0001);
    chk("first_id", grant_id, 0);
    chk("first_vld", grant_vld, 1);

    // 2. Lock then hand-off without an idle bubble.
    req = 4'b0101;
    repeat (HOLD2) @(negedge clk);
    chk("lock_grant", grant, 4'b0001);
    req = 4'b0100;
    @(negedge clk);
    chk("handoff_grant", grant, 4'b0100);
    chk("handoff_id", grant_id, 2);
    chk("handoff_vld", grant_vld, 1);

    // 3. Fairness rotation including 3->0 wrap.
    rst_n = 1'b0;
    req   = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 5; r++) begin
      chk("fair_order", grant, N'(1) << (r % N));
      repeat (2) @(negedge clk);
      req[r % N] = 1'b0;
      @(negedge clk);
      req[r % N] = 1'b1;
    end

    // 4. Return to idle and re-grant after a scan from ptr=2.
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    chk("idle_grant", grant, 4'b0000);
    chk("idle_vld", grant_vld, 0);
    req = 4'b0010;
    @(negedge clk);
    chk("regrant", grant, 4'b0010);
    chk("regrant_id", grant_id, 1);

    // 5. Hold limit.
    rst_n = 1'b0;
    req   = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("hold_start", grant, 4'b0001);
    cnt = 1;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != 4'b0001) break;
      cnt++;
    end
    chk("hold_cycles", cnt, 8);
    chk("timeout_pulse", timeout, 1);
    chk("timeout_winner", grant, 4'b0010);
    @(negedge clk);
    chk("timeout_clear", timeout, 0);
    chk("after_timeout", grant, 4'b0010);
`else
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (grant == 4'b0001 && timeout == 1'b0) cnt++;
    end
    chk("hold_cycles", cnt, 100);
`endif

    // 6. Asynchronous reset in the middle of a grant.
    req = 4'b1000;
    @(negedge clk);
    chk("pre_reset_grant", grant, 4'b1000);
    chk("pre_reset_id", grant_id, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {grant, grant_vld, grant_id, timeout}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_grant", grant, 4'b1000);
    chk("post_reset_id", grant_id, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
